// File: rtl/rotate_frame_ctrl_if.sv
// ----------------------------------------------------------------------------
// rotate_frame_ctrl_if
// Purpose : bundles the control, pixel-stream and SRAM signals of
//           rotate_frame_ctrl into one interface.
// Signals : start, rot_sel            frame control
//           in_valid/in_ready/in_data input RGB888 raster stream
//           out_valid/out_ready/out_data/out_line_start/out_frame_end
//                                     rotated output stream with row/frame flags
//           busy                      controller not idle
//           sram_en/we/addr/wdata/rdata single-port frame SRAM
// Modports: slave  - the controller side
//           master - the environment driving the controller
// ----------------------------------------------------------------------------
interface rotate_frame_ctrl_if;
   localparam int unsigned PIX_W  = 24;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned WORD_W = 32;

   logic              start;
   logic [1:0]        rot_sel;
   logic              in_valid;
   logic              in_ready;
   logic [PIX_W-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [PIX_W-1:0]  out_data;
   logic              out_line_start;
   logic              out_frame_end;
   logic              busy;
   logic              sram_en;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [WORD_W-1:0] sram_wdata;
   logic [WORD_W-1:0] sram_rdata;

   modport slave (
      input  start, rot_sel, in_valid, in_data, out_ready, sram_rdata,
      output in_ready, out_valid, out_data, out_line_start, out_frame_end,
             busy, sram_en, sram_we, sram_addr, sram_wdata
   );

   modport master (
      output start, rot_sel, in_valid, in_data, out_ready, sram_rdata,
      input  in_ready, out_valid, out_data, out_line_start, out_frame_end,
             busy, sram_en, sram_we, sram_addr, sram_wdata
   );
endinterface

// File: rtl/rotate_frame_ctrl.sv
// ----------------------------------------------------------------------------
// rotate_frame_ctrl
// Purpose : buffers one square RGB888 frame (2**COORD_W per side, 256x256 by
//           default) in a single-port SRAM, then streams it back out
//           transposed, rotated CW90, CCW90 or 180 degrees.
// Ports   : clk    - system clock, rising edge
//           rst    - asynchronous active-high reset
//           io_bus - rotate_frame_ctrl_if.slave (control, pixel streams, SRAM)
// Notes   : SRAM read data arrives one cycle after the read is issued and is
//           captured into a 2-entry output buffer. Reads are issued from the
//           current state so one pixel per cycle is sustained without ever
//           overrunning the buffer.
// ----------------------------------------------------------------------------
module rotate_frame_ctrl #(
   parameter int unsigned COORD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   rotate_frame_ctrl_if.slave   io_bus
);

   localparam int unsigned PIX_W  = 24;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned WORD_W = 32;
   localparam logic [COORD_W-1:0] C_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   // One output buffer entry: pixel plus the flags that travel with it.
   typedef struct packed {
      logic             ls;
      logic             fe;
      logic [PIX_W-1:0] data;
   } ent_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_rot;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic               r_pend;
   logic               r_pend_ls;
   logic               r_pend_fe;
   logic               r_vld0;
   logic               r_vld1;
   ent_t               r_buf0;
   ent_t               r_buf1;

   logic               w_beat;
   logic               w_pop;
   logic               w_issue;
   logic               w_last_xy;
   logic [1:0]         w_occ;
   logic [COORD_W-1:0] w_sx;
   logic [COORD_W-1:0] w_sy;
   ent_t               w_push;
   logic               w_vld0_nxt;
   logic               w_vld1_nxt;
   ent_t               w_buf0_nxt;
   ent_t               w_buf1_nxt;
   logic               w_unused_rdata;

   assign w_unused_rdata = ^io_bus.sram_rdata[WORD_W-1:PIX_W];

   assign w_beat    = (r_state == S_LOAD) && io_bus.in_valid;
   assign w_pop     = r_vld0 && io_bus.out_ready;
   assign w_last_xy = (r_x == C_MAX) && (r_y == C_MAX);

   // Entries left after this cycle's pop plus the read landing this cycle;
   // a new read is only allowed if it will still find a free slot.
   assign w_occ   = 2'(r_vld0) + 2'(r_vld1) - 2'(w_pop) + 2'(r_pend);
   assign w_issue = (r_state == S_DRAIN) && (w_occ < 2'd2);

   // Source coordinate for output position (ox,oy) = (r_x,r_y).
   always_comb begin
      w_sx = r_y;
      w_sy = r_x;
      case (r_rot)
         2'd1:    begin w_sx = r_y;          w_sy = C_MAX - r_x; end
         2'd2:    begin w_sx = C_MAX - r_y;  w_sy = r_x;         end
         2'd3:    begin w_sx = C_MAX - r_x;  w_sy = C_MAX - r_y; end
         default: begin w_sx = r_y;          w_sy = r_x;         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (io_bus.start)            w_state_nxt = S_LOAD;
         S_LOAD:  if (w_beat && w_last_xy)     w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_issue && w_last_xy)    w_state_nxt = S_FLUSH;
         S_FLUSH: if (w_pop && r_buf0.fe)      w_state_nxt = S_IDLE;
         default:                              w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode: stream ready, busy and SRAM port.
   always_comb begin
      io_bus.in_ready   = 1'b0;
      io_bus.busy       = 1'b0;
      io_bus.sram_en    = 1'b0;
      io_bus.sram_we    = 1'b0;
      io_bus.sram_addr  = '0;
      io_bus.sram_wdata = '0;
      case (r_state)
         S_LOAD: begin
            io_bus.in_ready = 1'b1;
            io_bus.busy     = 1'b1;
            if (io_bus.in_valid) begin
               io_bus.sram_en    = 1'b1;
               io_bus.sram_we    = 1'b1;
               io_bus.sram_addr  = ADDR_W'({r_y, r_x});
               io_bus.sram_wdata = WORD_W'(io_bus.in_data);
            end
         end
         S_DRAIN: begin
            io_bus.busy = 1'b1;
            if (w_issue) begin
               io_bus.sram_en   = 1'b1;
               io_bus.sram_addr = ADDR_W'({w_sy, w_sx});
            end
         end
         S_FLUSH: io_bus.busy = 1'b1;
         default: ;
      endcase
   end

   assign io_bus.out_valid      = r_vld0;
   assign io_bus.out_data       = r_buf0.data;
   assign io_bus.out_line_start = r_buf0.ls;
   assign io_bus.out_frame_end  = r_buf0.fe;

   // Buffer update: pop shifts the tail forward, landing read fills first free slot.
   always_comb begin
      w_push.ls   = r_pend_ls;
      w_push.fe   = r_pend_fe;
      w_push.data = io_bus.sram_rdata[PIX_W-1:0];
      w_vld0_nxt  = r_vld0;
      w_vld1_nxt  = r_vld1;
      w_buf0_nxt  = r_buf0;
      w_buf1_nxt  = r_buf1;
      if (w_pop) begin
         w_buf0_nxt = r_buf1;
         w_vld0_nxt = r_vld1;
         w_vld1_nxt = 1'b0;
      end
      if (r_pend) begin
         if (!w_vld0_nxt) begin
            w_buf0_nxt = w_push;
            w_vld0_nxt = 1'b1;
         end else begin
            w_buf1_nxt = w_push;
            w_vld1_nxt = 1'b1;
         end
      end
   end

   // Counters, in-flight read tracking and output buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rot     <= 2'd0;
         r_x       <= '0;
         r_y       <= '0;
         r_pend    <= 1'b0;
         r_pend_ls <= 1'b0;
         r_pend_fe <= 1'b0;
         r_vld0    <= 1'b0;
         r_vld1    <= 1'b0;
         r_buf0    <= '0;
         r_buf1    <= '0;
      end else begin
         if ((r_state == S_IDLE) && io_bus.start) begin
            r_rot <= io_bus.rot_sel;
            r_x   <= '0;
            r_y   <= '0;
         end else if (w_beat || w_issue) begin
            // Raster walk; wraps to (0,0) at frame end so DRAIN starts clean.
            r_x <= r_x + COORD_W'(1);
            if (r_x == C_MAX) r_y <= r_y + COORD_W'(1);
         end
         r_pend    <= w_issue;
         r_pend_ls <= (r_x == '0);
         r_pend_fe <= w_last_xy;
         r_vld0    <= w_vld0_nxt;
         r_vld1    <= w_vld1_nxt;
         r_buf0    <= w_buf0_nxt;
         r_buf1    <= w_buf1_nxt;
      end
   end

endmodule

// File: tb/tb_rotate_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rotate_frame_ctrl
// Purpose : directed self-checking bench for rotate_frame_ctrl, run on a
//           16x16 frame (COORD_W=4) with a behavioural single-port SRAM.
// ----------------------------------------------------------------------------
module tb_rotate_frame_ctrl;

   localparam int unsigned CW = 4;
   localparam int N  = 16;
   localparam int NN = 256;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rotate_frame_ctrl_if bus ();

   rotate_frame_ctrl #(.COORD_W(CW)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   // Single-port SRAM, read data one cycle after issue.
   logic [31:0] mem [0:NN-1];
   always @(posedge clk) begin
      if (bus.sram_en) begin
         if (bus.sram_we) mem[bus.sram_addr[2*CW-1:0]] <= bus.sram_wdata;
         else             bus.sram_rdata <= mem[bus.sram_addr[2*CW-1:0]];
      end
   end

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int lx, ly, beats, k, rd;
   int first_valid, last_beat, last_pop;
   int exp_mode;
   logic busy_at_last_pop;
   logic prev_stall;
   logic [25:0] held;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] pix(input int x, input int y);
      return {8'(y), 8'(x), 8'(x * 7 + y * 3) ^ 8'h5A};
   endfunction

   // Expected {line_start, frame_end, data} for output beat kk.
   function automatic logic [25:0] exp_out(input int kk);
      int ox, oy, sx, sy;
      ox = kk % N;
      oy = kk / N;
      case (exp_mode)
         0:       begin sx = oy;         sy = ox;         end
         1:       begin sx = oy;         sy = N - 1 - ox; end
         2:       begin sx = N - 1 - oy; sy = ox;         end
         default: begin sx = N - 1 - ox; sy = N - 1 - oy; end
      endcase
      return {ox == 0, kk == NN - 1, pix(sx, sy)};
   endfunction

   function automatic logic [82:0] outs_vec();
      return {bus.in_ready, bus.out_valid, bus.out_line_start, bus.out_frame_end,
              bus.busy, bus.sram_en, bus.sram_we, bus.out_data, bus.sram_addr,
              bus.sram_wdata};
   endfunction

   task automatic reset_model();
      lx = 0; ly = 0; beats = 0; k = 0; rd = 0;
      first_valid = -1; last_beat = -1; last_pop = -1;
      busy_at_last_pop = 1'b0;
      prev_stall = 1'b0;
      held = '0;
   endtask

   // One clock: observe mid-cycle, then return just after the next rising edge.
   task automatic tick();
      logic [25:0] cur;
      @(negedge clk);
      cyc++;
      cur = {bus.out_line_start, bus.out_frame_end, bus.out_data};
      if (bus.in_valid && bus.in_ready) begin
         check("load_write", {bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata},
               {1'b1, 1'b1, 20'(ly * N + lx), 8'h00, pix(lx, ly)});
         beats++;
         if (beats == NN) last_beat = cyc;
         if (lx == N - 1) begin lx = 0; ly++; end
         else lx++;
      end
      if (bus.sram_en) check("we_only_on_load_beat", bus.sram_we, bus.in_ready & bus.in_valid);
      if (bus.out_valid && prev_stall) check("stall_hold", cur, held);
      prev_stall = bus.out_valid & ~bus.out_ready;
      held = cur;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.sram_en && !bus.sram_we) rd++;
      if (bus.out_valid && bus.out_ready) begin
         check($sformatf("out_beat_%0d", k), cur, exp_out(k));
         if (k == NN - 1) begin
            last_pop = cyc;
            busy_at_last_pop = bus.busy;
         end
         k++;
      end
      if (bus.sram_en && !bus.sram_we) check("read_budget", 128'(rd - k <= 2), 128'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int mode);
      reset_model();
      exp_mode = mode;
      bus.rot_sel = 2'(mode);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.rot_sel = 2'(mode + 1);
      check("start_busy_ready", {bus.busy, bus.in_ready}, 2'b11);
   endtask

   task automatic load_beats(input int n, input bit gaps);
      int target, guard;
      target = beats + n;
      guard = 0;
      while (beats < target && guard < 8 * n + 20) begin
         bus.in_valid = gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1;
         bus.in_data = pix(lx, ly);
         tick();
         guard++;
      end
      bus.in_valid = 1'b0;
      check("load_count", beats, target);
   endtask

   task automatic drain_pops(input int n, input bit bp);
      int target, guard;
      target = k + n;
      guard = 0;
      bus.in_valid = 1'b0;
      while (k < target && guard < 20 * n + 50) begin
         bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         guard++;
      end
      bus.out_ready = 1'b1;
      check("drain_count", k, target);
   endtask

   task automatic frame_timing(input string tag);
      check({tag, "_latency"}, first_valid - last_beat, 3);
      check({tag, "_throughput"}, last_pop - first_valid, NN - 1);
   endtask

   task automatic busy_fall(input string tag);
      check({tag, "_busy_fall"}, {busy_at_last_pop, bus.busy}, 2'b10);
   endtask

   task automatic reset_pulse(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_during"}, outs_vec(), '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check({tag, "_release"}, outs_vec(), '0);
      tick();
      check({tag, "_no_stale"}, {bus.out_valid, bus.busy, bus.in_ready}, 3'b000);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.rot_sel = 2'd0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      exp_mode = 0;
      reset_model();

      #12;
      check("reset_outs_during", outs_vec(), '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_outs_release", outs_vec(), '0);
      tick();
      check("idle_outs", outs_vec(), '0);

      // Transpose, full rate.
      bus.out_ready = 1'b1;
      do_start(0);
      load_beats(NN, 0);
      check("drain_no_inready", bus.in_ready, 1'b0);
      drain_pops(NN, 0);
      frame_timing("transpose");
      busy_fall("transpose");

      // CW90 with start/rot_sel glitches during LOAD and DRAIN.
      do_start(1);
      load_beats(20, 0);
      bus.start = 1'b1;
      bus.rot_sel = 2'd2;
      load_beats(1, 0);
      bus.start = 1'b0;
      check("start_ignored_load", {bus.busy, bus.in_ready}, 2'b11);
      load_beats(NN - 21, 0);
      bus.start = 1'b1;
      bus.rot_sel = 2'd3;
      drain_pops(10, 0);
      bus.start = 1'b0;
      drain_pops(NN - 10, 0);
      frame_timing("cw90");
      busy_fall("cw90");
      check("cw90_stays_idle", {bus.busy, bus.in_ready}, 2'b00);

      // CCW90 and rot180, full rate.
      do_start(2);
      load_beats(NN, 0);
      drain_pops(NN, 0);
      frame_timing("ccw90");
      busy_fall("ccw90");

      do_start(3);
      load_beats(NN, 0);
      drain_pops(NN, 0);
      frame_timing("rot180");
      busy_fall("rot180");

      // rot180 and transpose with input gaps and random output backpressure.
      do_start(3);
      load_beats(NN, 1);
      drain_pops(NN, 1);
      busy_fall("rot180_bp");

      do_start(0);
      load_beats(NN, 1);
      drain_pops(NN, 1);
      busy_fall("transpose_bp");

      // Abandon a frame mid-LOAD, then mid-DRAIN.
      do_start(2);
      load_beats(100, 1);
      reset_pulse("rst_mid_load");

      do_start(0);
      load_beats(NN, 0);
      drain_pops(40, 1);
      reset_pulse("rst_mid_drain");

      // Fresh frame after the aborted ones.
      do_start(1);
      load_beats(NN, 1);
      drain_pops(NN, 1);
      busy_fall("cw90_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
